// File: rtl/fp_standardizer_pipe.sv
// fp_standardizer_pipe: 2-stage normalise + round/pack for the FP add/sub path.
// Define FP_STD_SUBNORMAL_EN to emit subnormals instead of flushing to zero.
module fp_standardizer_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [1:0]       rnd_mode,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [MAN_W+2:0] mantis_in,
  input  logic             loss,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mantis_out,
  output logic             sign_out,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_inexact,
  output logic             flag_zero
);

  localparam int LW = $clog2(MAN_W + 3);
  localparam int CW = ((EXP_W > LW) ? EXP_W : LW) + 1;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  function automatic logic [LW-1:0] lzc_f(input logic [MAN_W+1:0] v);
    lzc_f = LW'(MAN_W + 2);
    for (int i = 0; i <= MAN_W + 1; i++) begin
      if (v[i]) lzc_f = LW'(MAN_W + 1 - i);
    end
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [EXP_W:0]   s1_exp_q, s1_exp_d;
  logic [MAN_W+1:0] s1_man_q, s1_man_d;
  logic             s1_stk_q, s1_stk_d;
  logic             s1_sub_q, s1_sub_d;
  logic             s1_flush_q, s1_flush_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_sign_q, s1_sign_d;
  logic [1:0]       s1_mode_q, s1_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic [MAN_W-1:0] frac_out_q, frac_out_d;
  logic             sign_out_q, sign_out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             inx_q, inx_d;
  logic             zero_q, zero_d;

  logic s1_adv, s2_adv;
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  logic [MAN_W+1:0] man_lo;
  logic [LW-1:0]    lzc;
  logic [CW-1:0]    lzc_c, exp_c;
  assign man_lo = mantis_in[MAN_W+1:0];
  assign lzc    = lzc_f(man_lo);
  assign lzc_c  = CW'(lzc);
  assign exp_c  = CW'(exp_in);

`ifdef FP_STD_SUBNORMAL_EN
  logic [EXP_W-1:0] sub_sh;
  assign sub_sh = (exp_in == '0) ? '0 : exp_in - 1'b1;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_exp_d   = s1_exp_q;
    s1_man_d   = s1_man_q;
    s1_stk_d   = s1_stk_q;
    s1_sub_d   = s1_sub_q;
    s1_flush_d = s1_flush_q;
    s1_zero_d  = s1_zero_q;
    s1_sign_d  = s1_sign_q;
    s1_mode_d  = s1_mode_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = sign_in;
        s1_mode_d  = rnd_mode;
        s1_exp_d   = {1'b0, exp_in};
        s1_man_d   = man_lo;
        s1_stk_d   = loss;
        s1_sub_d   = 1'b0;
        s1_flush_d = 1'b0;
        s1_zero_d  = 1'b0;
        if (mantis_in[MAN_W+2]) begin
          s1_man_d = mantis_in[MAN_W+2:1];
          s1_exp_d = {1'b0, exp_in} + 1'b1;
          s1_stk_d = loss | mantis_in[0];
        end else if (man_lo == '0) begin
          s1_zero_d = 1'b1;
          s1_exp_d  = '0;
        end else if (lzc_c < exp_c) begin
          s1_man_d = man_lo << lzc;
          s1_exp_d = {1'b0, exp_in} - (EXP_W + 1)'(lzc);
        end else begin
`ifdef FP_STD_SUBNORMAL_EN
          s1_sub_d   = 1'b1;
          s1_exp_d   = '0;
          s1_man_d   = man_lo << sub_sh;
`else
          s1_flush_d = 1'b1;
          s1_exp_d   = '0;
          s1_man_d   = '0;
`endif
        end
      end
    end
  end

  logic             g, gs, inc, bump, to_inf;
  logic [MAN_W+1:0] sum;
  logic [EXP_W:0]   exp_r;
  logic [MAN_W-1:0] frac_r;

  always_comb begin
    g   = s1_man_q[0];
    gs  = g | s1_stk_q;
    inc = 1'b0;
    case (s1_mode_q)
      RNE:     inc = g & (s1_stk_q | s1_man_q[1]);
      RTZ:     inc = 1'b0;
      RUP:     inc = gs & !s1_sign_q;
      default: inc = gs & s1_sign_q;
    endcase
    sum    = {1'b0, s1_man_q[MAN_W+1:1]} + (MAN_W + 2)'(inc);
    // A subnormal whose rounding sets the hidden bit becomes the smallest normal.
    bump   = sum[MAN_W+1] | (s1_sub_q & sum[MAN_W]);
    exp_r  = s1_exp_q + (EXP_W + 1)'(bump);
    frac_r = sum[MAN_W+1] ? '0 : sum[MAN_W-1:0];
    to_inf = (s1_mode_q == RNE) ||
             ((s1_mode_q == RUP) && !s1_sign_q) ||
             ((s1_mode_q == RDN) && s1_sign_q);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    exp_out_d   = exp_out_q;
    frac_out_d  = frac_out_q;
    sign_out_d  = sign_out_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    zero_d      = zero_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sign_out_d = s1_sign_q;
        if (s1_zero_q || s1_flush_q) begin
          exp_out_d  = '0;
          frac_out_d = '0;
          ovf_d      = 1'b0;
          unf_d      = s1_flush_q;
          inx_d      = s1_flush_q | s1_stk_q;
          zero_d     = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
          exp_out_d  = to_inf ? {EXP_W{1'b1}} : {{(EXP_W-1){1'b1}}, 1'b0};
          frac_out_d = to_inf ? '0 : '1;
          ovf_d      = 1'b1;
          unf_d      = 1'b0;
          inx_d      = 1'b1;
          zero_d     = 1'b0;
        end else begin
          exp_out_d  = exp_r[EXP_W-1:0];
          frac_out_d = frac_r;
          ovf_d      = 1'b0;
          unf_d      = s1_sub_q & (exp_r == '0) & gs;
          inx_d      = gs;
          zero_d     = (exp_r == '0) && (frac_r == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_man_q    <= '0;
      s1_stk_q    <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_flush_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      exp_out_q   <= '0;
      frac_out_q  <= '0;
      sign_out_q  <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_exp_q    <= s1_exp_d;
      s1_man_q    <= s1_man_d;
      s1_stk_q    <= s1_stk_d;
      s1_sub_q    <= s1_sub_d;
      s1_flush_q  <= s1_flush_d;
      s1_zero_q   <= s1_zero_d;
      s1_sign_q   <= s1_sign_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      exp_out_q   <= exp_out_d;
      frac_out_q  <= frac_out_d;
      sign_out_q  <= sign_out_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign exp_out      = exp_out_q;
  assign mantis_out   = frac_out_q;
  assign sign_out     = sign_out_q;
  assign flag_ovf     = ovf_q;
  assign flag_unf     = unf_q;
  assign flag_inexact = inx_q;
  assign flag_zero    = zero_q;

endmodule
